// File: rtl/game_key_controls.sv
// Turns PS/2 make/brake key events into held movement levels, paced fire pulses, pause and start.
// Latency 1 cycle; no backpressure: events are consumed the cycle they arrive.
module game_key_controls #(
  parameter logic [8:0] KEY_LEFT    = 9'h16B,
  parameter logic [8:0] KEY_RIGHT   = 9'h174,
  parameter logic [8:0] KEY_FIRE    = 9'h029,
  parameter logic [8:0] KEY_START   = 9'h05A,
  parameter logic [8:0] KEY_PAUSE   = 9'h04D,
  parameter int unsigned FIRE_PERIOD = 8,
  parameter int unsigned FIRE_CNT_W  = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [8:0] keyCode,
  input  logic       make,
  input  logic       brake,
  input  logic       startOfFrame,
  output logic       move_left,
  output logic       move_right,
  output logic       fire_pulse,
  output logic       start_pulse,
  output logic       paused,
  output logic       any_key
);

  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;
  typedef enum logic {FIRE_IDLE = 1'b0, FIRE_HELD = 1'b1} fire_state_t;

  localparam logic [FIRE_CNT_W-1:0] FIRE_RELOAD = FIRE_CNT_W'(FIRE_PERIOD);
  localparam logic [FIRE_CNT_W-1:0] FIRE_LAST   = FIRE_CNT_W'(1);

  // brake dominates make, so a simultaneous make/brake is a release
  logic press, release_ev;
  logic hit_left, hit_right, hit_fire, hit_start, hit_pause;

  assign press      = make & ~brake;
  assign release_ev = brake;
  assign hit_left   = (keyCode == KEY_LEFT);
  assign hit_right  = (keyCode == KEY_RIGHT);
  assign hit_fire   = (keyCode == KEY_FIRE);
  assign hit_start  = (keyCode == KEY_START);
  assign hit_pause  = (keyCode == KEY_PAUSE);

  logic left_held_q, left_held_d;
  logic right_held_q, right_held_d;
  logic start_held_q, start_held_d;
  logic pause_held_q, pause_held_d;
  logic fire_held_q, fire_held_d;
  dir_t last_dir_q, last_dir_d;
  logic paused_q, paused_d;
  logic move_left_q, move_left_d;
  logic move_right_q, move_right_d;
  logic start_pulse_q, start_pulse_d;
  logic any_key_q, any_key_d;

  logic new_left, new_right, new_start, new_pause, new_fire, fire_rel;

  fire_state_t           fire_state_q;
  logic [FIRE_CNT_W-1:0] fire_cnt_q;
  logic                  fire_pulse_q;

  assign fire_held_q = (fire_state_q == FIRE_HELD);

  assign new_left  = press & hit_left  & ~left_held_q;
  assign new_right = press & hit_right & ~right_held_q;
  assign new_start = press & hit_start & ~start_held_q;
  assign new_pause = press & hit_pause & ~pause_held_q;
  assign new_fire  = press & hit_fire  & ~fire_held_q;
  assign fire_rel  = release_ev & hit_fire;

  always_comb begin
    left_held_d  = left_held_q;
    right_held_d = right_held_q;
    start_held_d = start_held_q;
    pause_held_d = pause_held_q;
    fire_held_d  = fire_held_q;
    if (press) begin
      if (hit_left)  left_held_d  = 1'b1;
      if (hit_right) right_held_d = 1'b1;
      if (hit_start) start_held_d = 1'b1;
      if (hit_pause) pause_held_d = 1'b1;
      if (hit_fire)  fire_held_d  = 1'b1;
    end else if (release_ev) begin
      if (hit_left)  left_held_d  = 1'b0;
      if (hit_right) right_held_d = 1'b0;
      if (hit_start) start_held_d = 1'b0;
      if (hit_pause) pause_held_d = 1'b0;
      if (hit_fire)  fire_held_d  = 1'b0;
    end
  end

  always_comb begin
    last_dir_d = last_dir_q;
    if (new_left)       last_dir_d = DIR_LEFT;
    else if (new_right) last_dir_d = DIR_RIGHT;
  end

  // Outputs are gated by the pause state they are presented alongside
  always_comb begin
    paused_d      = paused_q ^ new_pause;
    move_left_d   = left_held_d & (~right_held_d | (last_dir_d == DIR_LEFT)) & ~paused_d;
    move_right_d  = right_held_d & (~left_held_d | (last_dir_d == DIR_RIGHT)) & ~paused_d;
    start_pulse_d = new_start & ~paused_d;
    any_key_d     = left_held_d | right_held_d | fire_held_d | start_held_d | pause_held_d;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      left_held_q   <= 1'b0;
      right_held_q  <= 1'b0;
      start_held_q  <= 1'b0;
      pause_held_q  <= 1'b0;
      last_dir_q    <= DIR_LEFT;
      paused_q      <= 1'b0;
      move_left_q   <= 1'b0;
      move_right_q  <= 1'b0;
      start_pulse_q <= 1'b0;
      any_key_q     <= 1'b0;
    end else begin
      left_held_q   <= left_held_d;
      right_held_q  <= right_held_d;
      start_held_q  <= start_held_d;
      pause_held_q  <= pause_held_d;
      last_dir_q    <= last_dir_d;
      paused_q      <= paused_d;
      move_left_q   <= move_left_d;
      move_right_q  <= move_right_d;
      start_pulse_q <= start_pulse_d;
      any_key_q     <= any_key_d;
    end
  end

  // Fire auto-repeat: the press fires at once, then every FIRE_PERIOD frames while held
  always_ff @(posedge clk) begin
    if (!resetN) begin
      fire_state_q <= FIRE_IDLE;
      fire_cnt_q   <= '0;
      fire_pulse_q <= 1'b0;
    end else begin
      fire_pulse_q <= 1'b0;
      case (fire_state_q)
        FIRE_IDLE: begin
          if (new_fire) begin
            fire_state_q <= FIRE_HELD;
            fire_cnt_q   <= FIRE_RELOAD;
            fire_pulse_q <= ~paused_d;
          end
        end
        FIRE_HELD: begin
          if (fire_rel) begin
            fire_state_q <= FIRE_IDLE;
            fire_cnt_q   <= '0;
          end else if (startOfFrame && !paused_d) begin
            if (fire_cnt_q == FIRE_LAST) begin
              fire_cnt_q   <= FIRE_RELOAD;
              fire_pulse_q <= 1'b1;
            end else begin
              fire_cnt_q <= fire_cnt_q - FIRE_LAST;
            end
          end
        end
        default: begin
          fire_state_q <= FIRE_IDLE;
          fire_cnt_q   <= '0;
        end
      endcase
    end
  end

  assign move_left   = move_left_q;
  assign move_right  = move_right_q;
  assign fire_pulse  = fire_pulse_q;
  assign start_pulse = start_pulse_q;
  assign paused      = paused_q;
  assign any_key     = any_key_q;

endmodule
